mult_div_seq: RTL and testbench
===============================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 48, meaning the maximum cycles to wait for a unit done flag before aborting.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- MultReq  in  1  start multiply (single-cycle pulse from control unit)
- DivReq  in  1  start divide (single-cycle pulse)
- RegBOut  in  32  divisor operand, for the zero check
- MultDone  in  1  multiplier finished
- MultHIOut / MultLOOut  in  32 each  multiplier result
- DivDone  in  1  divider finished
- DivHIOut / DivLOOut  in  32 each  divider remainder/quotient
- MultCtrl  out  1  multiplier run enable
- DivCtrl  out  1  divider run enable
- HI / LO  out  32 each  architectural HI/LO registers
- Busy  out  1  stall request to control unit
- OpDone  out  1  one-cycle completion pulse
- DivZero  out  1  one-cycle divide-by-zero exception pulse
- Timeout  out  1  one-cycle watchdog abort pulse
REQ-003 SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, MULT_RUN, DIV_RUN, WRITEBACK, EXC.
REQ-005 SHALL accept requests only in IDLE; requests in any other state are ignored.
REQ-006 SHALL, in IDLE with MultReq=1, enter MULT_RUN next cycle and drive MultCtrl=1 from that cycle onward.
REQ-007 SHALL, in IDLE with MultReq=1 and DivReq=1 together, give multiply priority and drop DivReq.
REQ-008 SHALL, in IDLE with DivReq=1 and RegBOut=0, enter EXC and never assert DivCtrl.
REQ-009 SHALL, in IDLE with DivReq=1 and RegBOut!=0, enter DIV_RUN with DivCtrl=1.
REQ-010 SHALL hold MultCtrl (DivCtrl) high continuously in MULT_RUN (DIV_RUN), because the unit restarts if its enable drops.
REQ-011 SHALL, on the first cycle that MultDone (DivDone) =1 in the run state, latch the matching HI/LO inputs into internal result registers and go to WRITEBACK.
REQ-012 SHALL deassert MultCtrl and DivCtrl in WRITEBACK, EXC and IDLE.
REQ-013 SHALL, in WRITEBACK, load HI and LO from the latched results, pulse OpDone for one cycle, then return to IDLE.
REQ-014 SHALL, in EXC, pulse DivZero (or Timeout) for one cycle, leave HI/LO unchanged, then return to IDLE.
REQ-015 SHALL keep a 6-bit wait counter, cleared on entry to a run state and incremented each run cycle; when count reaches TIMEOUT with no done flag, go to EXC with Timeout.
REQ-016 SHALL assert Busy=1 in every state except IDLE, and also in the IDLE cycle where a request is accepted (combinational stall).
REQ-017 SHALL ignore a done flag that arrives while its own enable is low.
REQ-018 SHALL give end-to-end latency for a multiply of 36 cycles from MultReq to OpDone: 1 accept + 34 unit + 1 writeback.
REQ-019 SHALL change HI/LO only in WRITEBACK.

Reset
REQ-020 SHALL, on reset=1 and regardless of clock, force state IDLE, counter 0, HI=LO=0, and MultCtrl=DivCtrl=Busy=OpDone=DivZero=Timeout=0.
REQ-021 SHALL, on reset asserted mid-operation, abandon the operation, leave HI/LO at 0, and generate no completion pulse.
REQ-022 SHALL accept a new request on the first rising edge after reset deasserts.

Verification
REQ-023 SHALL pass: MultReq with model returning HI=0x00000001, LO=0x00000002 after 34 cycles -> MultCtrl high 34 cycles, OpDone at cycle 36, HI=1, LO=2.
REQ-024 SHALL pass: DivReq with RegBOut=0 -> DivCtrl never high, DivZero pulse at cycle 2, HI/LO unchanged, Busy low by cycle 3.
REQ-025 SHALL pass: MultReq and DivReq in the same cycle -> only MultCtrl asserted, DivCtrl stays 0 throughout.
REQ-026 SHALL pass: DivReq with RegBOut=7 and DivDone held 0 -> Timeout pulse after 48 run cycles, DivCtrl drops, HI/LO unchanged.
REQ-027 SHALL pass: reset pulsed at cycle 10 of MULT_RUN -> all outputs 0 immediately, no OpDone, next MultReq starts normally.
REQ-028 SHALL pass: MultReq repeated during MULT_RUN -> ignored; exactly one OpDone.

Source files
------------

// File: rtl/mult_div_seq_if.sv
// mult_div_seq_if
// Purpose : groups the control-unit handshake, the divisor operand, the
//           multiplier/divider unit handshakes and the HI/LO results of the
//           mult_div_seq sequencer into one bundle.
// Modports: slave  - the sequencer (takes requests and unit results, drives
//                    unit enables, HI/LO and status pulses)
//           master - the environment (control unit plus multiplier/divider)
interface mult_div_seq_if;
    logic        MultReq;
    logic        DivReq;
    logic [31:0] RegBOut;
    logic        MultDone;
    logic [31:0] MultHIOut;
    logic [31:0] MultLOOut;
    logic        DivDone;
    logic [31:0] DivHIOut;
    logic [31:0] DivLOOut;
    logic        MultCtrl;
    logic        DivCtrl;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        OpDone;
    logic        DivZero;
    logic        Timeout;

    modport slave (
        input  MultReq, DivReq, RegBOut,
        input  MultDone, MultHIOut, MultLOOut,
        input  DivDone, DivHIOut, DivLOOut,
        output MultCtrl, DivCtrl, HI, LO, Busy, OpDone, DivZero, Timeout
    );

    modport master (
        output MultReq, DivReq, RegBOut,
        output MultDone, MultHIOut, MultLOOut,
        output DivDone, DivHIOut, DivLOOut,
        input  MultCtrl, DivCtrl, HI, LO, Busy, OpDone, DivZero, Timeout
    );
endinterface

// File: rtl/mult_div_seq.sv
// mult_div_seq
// Purpose : sequences one multiply or divide at a time through external
//           iterative units, owns the architectural HI/LO registers, stalls
//           the control unit while busy and aborts a unit that never finishes.
// Ports   : clock   - sole clock, rising edge
//           reset   - asynchronous, active-high
//           bus     - mult_div_seq_if.slave (requests, unit handshakes,
//                     HI/LO, Busy, OpDone/DivZero/Timeout pulses)
// Param   : TIMEOUT - run cycles allowed before the watchdog aborts (1..64)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for MultReq/DivReq; units disabled
// MULT_RUN  | multiplier enabled, waiting for MultDone or watchdog
// DIV_RUN   | divider enabled, waiting for DivDone or watchdog
// WRITEBACK | latched result copied to HI/LO, OpDone pulsed
// EXC       | DivZero or Timeout pulsed, HI/LO untouched
module mult_div_seq #(
    parameter int TIMEOUT = 48
) (
    input logic          clock,
    input logic          reset,
    mult_div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MULT_RUN  = 3'd1,
        DIV_RUN   = 3'd2,
        WRITEBACK = 3'd3,
        EXC       = 3'd4
    } state_t;

    // Count holds (run cycles completed - 1) during a run, so matching the
    // last value means this is run cycle number TIMEOUT.
    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_wait_cnt;
    logic [5:0]  w_wait_cnt_nxt;
    logic        r_exc_tmo;
    logic        w_exc_tmo_nxt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_latch_mult;
    logic        w_latch_div;
    logic        w_expire;
    logic        w_req;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_exc_tmo_nxt  = r_exc_tmo;
        w_latch_mult   = 1'b0;
        w_latch_div    = 1'b0;
        w_expire       = (r_wait_cnt == TMO_LAST);

        case (r_state)
            IDLE: begin
                // Counter is held clear here so every run starts from 0.
                w_wait_cnt_nxt = '0;
                if (bus.MultReq) begin
                    // Multiply wins; a simultaneous DivReq is dropped.
                    w_next_state = MULT_RUN;
                end else if (bus.DivReq) begin
                    if (bus.RegBOut == 32'd0) begin
                        w_next_state  = EXC;
                        w_exc_tmo_nxt = 1'b0;
                    end else begin
                        w_next_state = DIV_RUN;
                    end
                end
            end

            MULT_RUN: begin
                // Only MultDone is looked at here; a stray DivDone is ignored.
                // A done flag on the final allowed cycle beats the watchdog.
                if (bus.MultDone) begin
                    w_latch_mult = 1'b1;
                    w_next_state = WRITEBACK;
                end else if (w_expire) begin
                    w_next_state  = EXC;
                    w_exc_tmo_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 6'd1;
                end
            end

            DIV_RUN: begin
                if (bus.DivDone) begin
                    w_latch_div  = 1'b1;
                    w_next_state = WRITEBACK;
                end else if (w_expire) begin
                    w_next_state  = EXC;
                    w_exc_tmo_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 6'd1;
                end
            end

            WRITEBACK: w_next_state = IDLE;
            EXC:       w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_exc_tmo  <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_exc_tmo  <= w_exc_tmo_nxt;

            // Results are captured on the done cycle itself; the unit is
            // free to change its outputs once its enable drops.
            if (w_latch_mult) begin
                r_res_hi <= bus.MultHIOut;
                r_res_lo <= bus.MultLOOut;
            end else if (w_latch_div) begin
                r_res_hi <= bus.DivHIOut;
                r_res_lo <= bus.DivLOOut;
            end

            // HI/LO are written only by the WRITEBACK cycle, so they show the
            // new value from the cycle after the OpDone pulse.
            if (r_state == WRITEBACK) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The accept-cycle stall is combinational from the request; reset masks
    // it so Busy is 0 for as long as reset is asserted.
    assign w_req = (bus.MultReq | bus.DivReq) & ~reset;

    assign bus.MultCtrl = (r_state == MULT_RUN);
    assign bus.DivCtrl  = (r_state == DIV_RUN);
    assign bus.Busy     = (r_state != IDLE) | w_req;
    assign bus.OpDone   = (r_state == WRITEBACK);
    assign bus.DivZero  = (r_state == EXC) & ~r_exc_tmo;
    assign bus.Timeout  = (r_state == EXC) &  r_exc_tmo;
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq
// Directed stimulus against mult_div_seq. Multiplier/divider emulators finish
// after a programmable number of enabled cycles. A timeline model fills
// per-cycle expectation arrays when a request is issued; one compare process
// checks every output on every falling edge, and literal checks pin the
// model to hand-computed cycle counts and values.
module tb_mult_div_seq;
    localparam int TMO = 48;
    localparam int N   = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    mult_div_seq_if bus();

    mult_div_seq #(.TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // ------------------------------------------------------------------
    // Unit emulators: done in the L-th consecutive enabled cycle (L=0: never)
    // ------------------------------------------------------------------
    int          m_lat = 34, d_lat = 10;
    int          m_run = 0,  d_run = 0;
    logic        m_gen = 1'b0, d_gen = 1'b0;
    logic        m_stray = 1'b0, d_stray = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;

    always @(negedge clock) begin
        if (bus.MultCtrl === 1'b1) begin
            m_gen = (m_lat > 0) && (m_run == m_lat - 1);
            m_run++;
        end else begin
            m_gen = 1'b0;
            m_run = 0;
        end
        if (bus.DivCtrl === 1'b1) begin
            d_gen = (d_lat > 0) && (d_run == d_lat - 1);
            d_run++;
        end else begin
            d_gen = 1'b0;
            d_run = 0;
        end
    end

    // Outside the done cycle the units present junk so late capture shows up.
    assign bus.MultDone  = m_gen | m_stray;
    assign bus.MultHIOut = m_gen ? m_hi : 32'hDEAD_BEEF;
    assign bus.MultLOOut = m_gen ? m_lo : 32'hDEAD_BEEF;
    assign bus.DivDone   = d_gen | d_stray;
    assign bus.DivHIOut  = d_gen ? d_hi : 32'hBADC_0DE5;
    assign bus.DivLOOut  = d_gen ? d_lo : 32'hBADC_0DE5;

    // ------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------
    bit          e_mc [N];
    bit          e_dc [N];
    bit          e_busy [N];
    bit          e_op [N];
    bit          e_dz [N];
    bit          e_to [N];
    logic [31:0] e_hi [N];
    logic [31:0] e_lo [N];
    int          free_at = N;

    task automatic model_req(input int c, input bit mr, input bit dr, input logic [31:0] rb);
        int          lat;
        int          n;
        bit          ok;
        logic [31:0] vh, vl;
        if (c < free_at || !(mr || dr)) return;
        e_busy[c] = 1'b1;
        if (!mr && rb == 32'd0) begin
            e_busy[c+1] = 1'b1;
            e_dz[c+1]   = 1'b1;
            free_at     = c + 2;
            return;
        end
        lat = mr ? m_lat : d_lat;
        vh  = mr ? m_hi  : d_hi;
        vl  = mr ? m_lo  : d_lo;
        ok  = (lat >= 1) && (lat <= TMO);
        n   = ok ? lat : TMO;
        for (int i = 1; i <= n; i++) begin
            e_busy[c+i] = 1'b1;
            if (mr) e_mc[c+i] = 1'b1;
            else    e_dc[c+i] = 1'b1;
        end
        e_busy[c+n+1] = 1'b1;
        if (ok) begin
            e_op[c+n+1] = 1'b1;
            for (int j = c + n + 2; j < N; j++) begin
                e_hi[j] = vh;
                e_lo[j] = vl;
            end
        end else begin
            e_to[c+n+1] = 1'b1;
        end
        free_at = c + n + 2;
    endtask

    task automatic model_reset(input int c);
        for (int j = c; j < N; j++) begin
            e_mc[j] = 0; e_dc[j] = 0; e_busy[j] = 0;
            e_op[j] = 0; e_dz[j] = 0; e_to[j] = 0;
            e_hi[j] = '0; e_lo[j] = '0;
        end
        free_at = N;
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    bit run_chk = 1'b1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (run_chk && cyc < N) begin
            check("MultCtrl", 32'(bus.MultCtrl), 32'(e_mc[cyc]));
            check("DivCtrl",  32'(bus.DivCtrl),  32'(e_dc[cyc]));
            check("Busy",     32'(bus.Busy),     32'(e_busy[cyc]));
            check("OpDone",   32'(bus.OpDone),   32'(e_op[cyc]));
            check("DivZero",  32'(bus.DivZero),  32'(e_dz[cyc]));
            check("Timeout",  32'(bus.Timeout),  32'(e_to[cyc]));
            check("HI",       bus.HI,            e_hi[cyc]);
            check("LO",       bus.LO,            e_lo[cyc]);
        end
    end

    // Pulse/enable tallies for the literal checks
    int cnt_mc = 0, cnt_dc = 0, cnt_op = 0, cnt_dz = 0, cnt_to = 0;
    int last_op = -1, last_dz = -1, last_to = -1;

    always @(negedge clock) begin
        if (bus.MultCtrl === 1'b1) cnt_mc++;
        if (bus.DivCtrl  === 1'b1) cnt_dc++;
        if (bus.OpDone   === 1'b1) begin cnt_op++; last_op = cyc; end
        if (bus.DivZero  === 1'b1) begin cnt_dz++; last_dz = cyc; end
        if (bus.Timeout  === 1'b1) begin cnt_to++; last_to = cyc; end
    end

    task automatic clear_counts();
        cnt_mc = 0; cnt_dc = 0; cnt_op = 0; cnt_dz = 0; cnt_to = 0;
        last_op = -1; last_dz = -1; last_to = -1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic request(input bit mr, input bit dr, input logic [31:0] rb);
        bus.MultReq = mr;
        bus.DivReq  = dr;
        bus.RegBOut = rb;
        model_req(cyc, mr, dr, rb);
        step();
        bus.MultReq = 1'b0;
        bus.DivReq  = 1'b0;
    endtask

    int a;

    initial begin
        bus.MultReq = 1'b0;
        bus.DivReq  = 1'b0;
        bus.RegBOut = '0;

        // Reset state, with a request held during reset (must not stall)
        idle(2);
        request(1'b1, 1'b0, 32'd0);
        bus.MultReq = 1'b1;
        #1;
        check("reset_busy_masked", 32'(bus.Busy), 32'd0);
        check("reset_hi", bus.HI, 32'd0);
        bus.MultReq = 1'b0;
        step();
        reset   = 1'b0;
        free_at = cyc;

        // Multiply, 34-cycle unit, accepted right after reset release
        m_lat = 34; m_hi = 32'h0000_0001; m_lo = 32'h0000_0002;
        clear_counts();
        a = cyc;
        request(1'b1, 1'b0, 32'd0);
        idle(38);
        check("mult_ctrl_cycles", cnt_mc, 34);
        check("mult_opdone_cycle", last_op - a + 1, 36);
        check("mult_opdone_count", cnt_op, 1);
        check("mult_hi", bus.HI, 32'h0000_0001);
        check("mult_lo", bus.LO, 32'h0000_0002);

        // Divide by zero
        clear_counts();
        a = cyc;
        request(1'b0, 1'b1, 32'd0);
        idle(3);
        check("dz_divctrl", cnt_dc, 0);
        check("dz_pulse_cycle", last_dz - a + 1, 2);
        check("dz_count", cnt_dz, 1);
        check("dz_busy_low", 32'(bus.Busy), 32'd0);
        check("dz_hi_kept", bus.HI, 32'h0000_0001);

        // Simultaneous MultReq and DivReq
        m_lat = 5; m_hi = 32'h1111_1111; m_lo = 32'h2222_2222;
        clear_counts();
        request(1'b1, 1'b1, 32'd3);
        idle(10);
        check("both_divctrl", cnt_dc, 0);
        check("both_multctrl", cnt_mc, 5);
        check("both_hi", bus.HI, 32'h1111_1111);

        // Divider never finishes
        d_lat = 0;
        clear_counts();
        a = cyc;
        request(1'b0, 1'b1, 32'd7);
        idle(52);
        check("tmo_divctrl_cycles", cnt_dc, 48);
        check("tmo_count", cnt_to, 1);
        check("tmo_cycle", last_to - a, 49);
        check("tmo_no_opdone", cnt_op, 0);
        check("tmo_hi_kept", bus.HI, 32'h1111_1111);
        check("tmo_lo_kept", bus.LO, 32'h2222_2222);

        // Normal divide with stray MultDone during the run
        d_lat = 10; d_hi = 32'd5; d_lo = 32'h0000_1234;
        clear_counts();
        a = cyc;
        request(1'b0, 1'b1, 32'h10);
        idle(3);
        m_stray = 1'b1;
        step();
        m_stray = 1'b0;
        idle(10);
        check("div_ctrl_cycles", cnt_dc, 10);
        check("div_opdone_cycle", last_op - a, 11);
        check("div_hi", bus.HI, 32'd5);
        check("div_lo", bus.LO, 32'h0000_1234);

        // Stray done flags while idle
        clear_counts();
        m_stray = 1'b1; d_stray = 1'b1;
        step();
        m_stray = 1'b0; d_stray = 1'b0;
        idle(3);
        check("stray_no_opdone", cnt_op, 0);

        // Reset in run cycle 10 of a multiply
        m_lat = 34; m_hi = 32'hAAAA_AAAA; m_lo = 32'h5555_5555;
        clear_counts();
        request(1'b1, 1'b0, 32'd0);
        idle(9);
        reset = 1'b1;
        model_reset(cyc);
        #1;
        check("rst_multctrl", 32'(bus.MultCtrl), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        idle(2);
        reset   = 1'b0;
        free_at = cyc;
        idle(36);
        check("rst_no_opdone", cnt_op, 0);
        m_lat = 3; m_hi = 32'h0000_0077; m_lo = 32'h0000_0088;
        clear_counts();
        request(1'b1, 1'b0, 32'd0);
        idle(6);
        check("post_rst_opdone", cnt_op, 1);
        check("post_rst_hi", bus.HI, 32'h0000_0077);

        // MultReq repeated during the run and on the writeback cycle
        m_lat = 20; m_hi = 32'h0000_0033; m_lo = 32'h0000_0044;
        clear_counts();
        request(1'b1, 1'b0, 32'd0);
        idle(5);
        request(1'b1, 1'b0, 32'd0);
        idle(3);
        request(1'b1, 1'b0, 32'd0);
        idle(10);
        request(1'b1, 1'b0, 32'd0);
        idle(3);
        check("repeat_one_opdone", cnt_op, 1);
        check("repeat_ctrl_cycles", cnt_mc, 20);

        // Done on the last allowed cycle beats the watchdog
        m_lat = 48; m_hi = 32'h0000_4848; m_lo = 32'h0000_0048;
        clear_counts();
        request(1'b1, 1'b0, 32'd0);
        idle(51);
        check("l48_opdone", cnt_op, 1);
        check("l48_timeout", cnt_to, 0);
        check("l48_hi", bus.HI, 32'h0000_4848);

        // One cycle too late: watchdog fires
        m_lat = 49;
        clear_counts();
        request(1'b1, 1'b0, 32'd0);
        idle(52);
        check("l49_timeout", cnt_to, 1);
        check("l49_opdone", cnt_op, 0);
        check("l49_ctrl_cycles", cnt_mc, 48);

        // One-cycle unit, request on writeback ignored, next one accepted
        m_lat = 1; m_hi = 32'h0000_0055; m_lo = 32'h0000_0066;
        clear_counts();
        a = cyc;
        request(1'b1, 1'b0, 32'd0);
        step();
        request(1'b0, 1'b1, 32'd0);
        request(1'b0, 1'b1, 32'd0);
        idle(4);
        check("b2b_opdone_cycle", last_op - a, 2);
        check("b2b_dz_count", cnt_dz, 1);
        check("b2b_dz_cycle", last_dz - a, 4);
        check("b2b_hi", bus.HI, 32'h0000_0055);

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
